serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl_pkg.sv | 17 +
 rtl/serial_sub_ctrl_fs_cell.sv | 24 ++
 rtl/serial_sub_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl_pkg
// Shared definitions for the bit-serial subtractor controller:
//   - state_t       : FSM state encodings (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand width in bits
// ---------------------------------------------------------------------------
package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// ---------------------------------------------------------------------------
// fs_cell
// Purely combinational 1-bit full subtractor computing x - y - bi.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// ---------------------------------------------------------------------------
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // A borrow is produced when y exceeds x outright, or when the bits
    // match and a borrow is already pending from the lower position.
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtractor: computes diff = a - b - bin (mod 2^WIDTH), one bit
// per clock, LSB first, through a single fs_cell.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the signed-overflow flag.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request an operation (sampled only while ready)
//   a, b  : minuend / subtrahend, sampled with start
//   bin   : initial borrow-in, sampled with start
//   ready : high in IDLE
//   busy  : high in RUN and DONE
//   done  : one-cycle completion pulse
//   diff  : result, held until the next accepted start
//   bout  : final borrow-out
//   ovf   : signed overflow (0 unless SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] opA_q,    opA_d;
    logic [WIDTH-1:0] opB_q,    opB_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             cellD;
    logic             cellBo;
    logic             lastBit;

    fs_cell uCell (
        .x  (opA_q[0]),
        .y  (opB_q[0]),
        .bi (borrow_q),
        .d  (cellD),
        .bo (cellBo)
    );

    assign lastBit = (state_q == RUN) && (cnt_q == LAST_BIT);

    // Next-state logic: IDLE loads operands on start, RUN consumes one bit
    // per edge, DONE lasts one cycle. The unused code 2'b11 falls back to IDLE.
    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        result_d = result_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d    = a;
                    opB_d    = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d = {cellD, result_q[WIDTH-1:1]};
                opA_d    = opA_q >> 1;
                opB_d    = opB_q >> 1;
                borrow_d = cellBo;
                // The counter parks on the last index so it never wraps.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow is the borrow entering the MSB cell XOR the borrow
    // leaving it; the borrow register still holds the former on the last bit.
    always_comb begin
        ovf_d = ovf_q;
        if (lastBit) begin
            ovf_d = borrow_q ^ cellBo;
        end
    end

    // Overflow flag register, held alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unusedLastBit;
    assign unusedLastBit = lastBit;
    assign ovf = 1'b0;
`endif

    assign ready = (state_q == IDLE);
    assign busy  = ~ready;
    assign done  = (state_q == DONE);
    assign diff  = result_q;
    assign bout  = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
// Scoreboard bench for serial_sub_ctrl at WIDTH=8. Stimulus pushes the
// hand-computed result when an operation is accepted; a monitor pops and
// compares whenever done is presented.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        int         acceptEdge;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    exp_t sbq[$];
    exp_t monItem;
    int   total     = 0;
    int   bad       = 0;
    int   edgeCount = 0;
    int   doneCount = 0;
    logic prevDone  = 1'b0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global edge counter used to measure done latency.
    always @(posedge clk) begin
        edgeCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: done is sampled mid-cycle. It is presented for the edge
    // acceptEdge+WIDTH+1, i.e. WIDTH edges after the accepting edge have passed.
    always @(negedge clk) begin
        if (rst_n && done) begin
            doneCount++;
            if (prevDone) begin
                total++;
                bad++;
                $display("[TB] FAIL done_pulse_width: got 2+ cycles expected 1");
            end
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done expected none");
            end else begin
                monItem = sbq.pop_front();
                checkOutput({monItem.name, "_diff"}, 32'(diff), 32'(monItem.diff));
                checkOutput({monItem.name, "_bout"}, 32'(bout), 32'(monItem.bout));
                checkOutput({monItem.name, "_ovf"}, 32'(ovf), 32'(monItem.ovf));
                checkOutput({monItem.name, "_latency"}, 32'(edgeCount - monItem.acceptEdge), 32'(WIDTH));
            end
        end
        prevDone = done;
    end

    // Waits for ready, presents one operation and records its expectation on
    // the accepting edge. Returns 1 ns after that edge with start dropped.
    task automatic applyStimulus(input string name, input logic [7:0] va, input logic [7:0] vb,
                                 input logic vbin, input logic [7:0] eDiff, input logic eBout,
                                 input logic eOvf);
        exp_t item;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_ready_timeout: got ready=0 expected 1", name);
        end
        start = 1'b1;
        a     = va;
        b     = vb;
        bin   = vbin;
        @(posedge clk);
        #1;
        item.name       = name;
        item.diff       = eDiff;
        item.bout       = eBout;
        item.ovf        = OVF_EN & eOvf;
        item.acceptEdge = edgeCount;
        sbq.push_back(item);
        start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_done_timeout: got pending=%0d expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int doneBefore;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        rst_n = 1'b0;
        #12;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_bout", 32'(bout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("v5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_ready", 32'(ready), 32'd0);
        waitDrain("v5a_3c");

        applyStimulus("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        waitDrain("v00_01");

        applyStimulus("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        waitDrain("v80_01");

        // Extra start pulses at edges 3 and 9 of this operation must be ignored.
        doneBefore = doneCount;
        applyStimulus("v10_10", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h00;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain("v10_10");
        repeat (4) @(negedge clk);
        checkOutput("ign_done_count", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("ign_ready", 32'(ready), 32'd1);
        checkOutput("ign_diff_hold", 32'(diff), 32'hFF);
        checkOutput("ign_bout_hold", 32'(bout), 32'd1);

        // Reset at RUN edge 4 aborts with no done pulse.
        doneBefore = doneCount;
        applyStimulus("vabort", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sbq.pop_back());
        #1;
        checkOutput("abort_ready", 32'(ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_bout", 32'(bout), 32'd0);
        checkOutput("abort_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);

        applyStimulus("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        waitDrain("v05_03");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
